// File: rtl/uart_par_pkg.sv
// Shared definitions for the UART parity engine: parity mode encodings,
// RX state type and the parity function used by both TX and RX paths.
package uart_par_pkg;

  localparam int MAX_W = 9;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PAR
  } rx_state_t;

  // A shift of MAX_W or more yields zero, so the subtraction gives all ones.
  function automatic logic [MAX_W-1:0] len_mask(input logic [31:0] len);
    len_mask = (MAX_W'(1) << len) - MAX_W'(1);
  endfunction

  function automatic logic par_calc(input logic [MAX_W-1:0] data,
                                    input logic [MAX_W-1:0] mask,
                                    input logic [1:0]       typ);
    logic x;
    x = ^(data & mask);
    case (typ)
      PAR_EVEN:  par_calc = x;
      PAR_ODD:   par_calc = ~x;
      PAR_MARK:  par_calc = 1'b1;
      PAR_SPACE: par_calc = 1'b0;
      default:   par_calc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_par_rx_chk.sv
// Serial RX parity checker: frame FSM, running XOR accumulator, bit counter
// and saturating error accounting.
module uart_par_rx_chk
  import uart_par_pkg::*;
#(
  parameter int LEN_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 par_en,
  input  logic [1:0]           par_typ,
  input  logic [LEN_W-1:0]     eff_len,
  input  logic                 s_start,
  input  logic                 s_bit,
  input  logic                 s_bit_valid,
  input  logic                 clear_err,
  output logic                 par_err,
  output logic                 frame_done,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  rx_state_t            state;
  logic                 acc;
  logic [LEN_W-1:0]     cnt;
  logic [LEN_W-1:0]     len_l;
  logic                 par_en_l;
  logic [1:0]           typ_l;
  logic [LEN_W-1:0]     cnt_next;
  logic                 exp_par;
  logic                 err_event;
  logic [ERR_CNT_W-1:0] cnt_base;

  assign cnt_next  = cnt + LEN_W'(1);
  // The accumulator already holds the XOR of the masked bits, so it is the
  // whole data word as far as the parity function is concerned.
  assign exp_par   = par_calc(MAX_W'(acc), MAX_W'(1), typ_l);
  assign err_event = (state == RX_PAR) && s_bit_valid && !s_start && (s_bit != exp_par);
  // Clear takes effect before a coincident error is counted.
  assign cnt_base  = clear_err ? '0 : err_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RX_IDLE;
      acc        <= 1'b0;
      cnt        <= '0;
      len_l      <= '0;
      par_en_l   <= 1'b0;
      typ_l      <= PAR_EVEN;
      par_err    <= 1'b0;
      frame_done <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      par_err    <= err_event;
      frame_done <= 1'b0;
      err_sticky <= err_event | (err_sticky & ~clear_err);
      err_cnt    <= (err_event && !(&cnt_base)) ? cnt_base + ERR_CNT_W'(1) : cnt_base;
      if (s_start) begin
        state    <= RX_DATA;
        acc      <= 1'b0;
        cnt      <= '0;
        len_l    <= eff_len;
        par_en_l <= par_en;
        typ_l    <= par_typ;
      end else if (s_bit_valid) begin
        case (state)
          RX_DATA: begin
            acc <= acc ^ s_bit;
            cnt <= cnt_next;
            if (cnt_next == len_l) begin
              if (par_en_l) begin
                state <= RX_PAR;
              end else begin
                frame_done <= 1'b1;
                state      <= RX_IDLE;
              end
            end
          end
          RX_PAR: begin
            frame_done <= 1'b1;
            state      <= RX_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_par_unit.sv
// UART parity engine top: TX parity generation from a parallel word and
// serial RX parity checking via uart_par_rx_chk.
module uart_par_unit
  import uart_par_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int ERR_CNT_W = 8,
  localparam int LEN_W     = $clog2(DATA_W + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 par_en,
  input  logic [1:0]           par_typ,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [DATA_W-1:0]    p_data,
  input  logic                 data_valid,
  output logic                 par_bit,
  output logic                 par_valid,
  input  logic                 s_start,
  input  logic                 s_bit,
  input  logic                 s_bit_valid,
  output logic                 par_err,
  output logic                 frame_done,
  input  logic                 clear_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [LEN_W-1:0] eff_len;
  logic [MAX_W-1:0] tx_mask;

  // Zero or out-of-range lengths fall back to the full data width.
  assign eff_len = (cfg_len == '0 || cfg_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cfg_len;
  assign tx_mask = len_mask(32'(eff_len));

  always_ff @(posedge clk) begin
    if (!reset) begin
      par_bit   <= 1'b0;
      par_valid <= 1'b0;
    end else begin
      par_valid <= data_valid;
      if (data_valid) begin
        par_bit <= par_calc(MAX_W'(p_data), tx_mask, par_typ);
      end
    end
  end

  uart_par_rx_chk #(
    .LEN_W     (LEN_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_rx_chk (
    .clk         (clk),
    .reset       (reset),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .eff_len     (eff_len),
    .s_start     (s_start),
    .s_bit       (s_bit),
    .s_bit_valid (s_bit_valid),
    .clear_err   (clear_err),
    .par_err     (par_err),
    .frame_done  (frame_done),
    .err_sticky  (err_sticky),
    .err_cnt     (err_cnt)
  );

endmodule

// File: tb/tb_uart_par_unit.sv
// Directed bench for uart_par_unit: table-driven TX parity vectors plus
// hand-written RX frame sequences for error accounting and restart cases.
module tb_uart_par_unit;

  localparam int DATA_W    = 8;
  localparam int ERR_CNT_W = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       par_en;
  logic [1:0] par_typ;
  logic [3:0] cfg_len;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_bit;
  logic       par_valid;
  logic       s_start;
  logic       s_bit;
  logic       s_bit_valid;
  logic       par_err;
  logic       frame_done;
  logic       clear_err;
  logic       err_sticky;
  logic [1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] typ;
    logic [3:0] len;
    logic       exp_par;
  } tx_vec_t;

  tx_vec_t tx_vecs[12];

  uart_par_unit #(
    .DATA_W    (DATA_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .cfg_len     (cfg_len),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .par_bit     (par_bit),
    .par_valid   (par_valid),
    .s_start     (s_start),
    .s_bit       (s_bit),
    .s_bit_valid (s_bit_valid),
    .par_err     (par_err),
    .frame_done  (frame_done),
    .clear_err   (clear_err),
    .err_sticky  (err_sticky),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input tx_vec_t v);
    p_data     = v.data;
    par_typ    = v.typ;
    cfg_len    = v.len;
    data_valid = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " par_bit"},    par_bit,    0);
    checkOutput({tag, " par_valid"},  par_valid,  0);
    checkOutput({tag, " par_err"},    par_err,    0);
    checkOutput({tag, " frame_done"}, frame_done, 0);
    checkOutput({tag, " err_sticky"}, err_sticky, 0);
    checkOutput({tag, " err_cnt"},    err_cnt,    0);
  endtask

  // Sends n bits LSB first (data then optional parity); frame_done must only
  // appear one cycle after the final strobe.
  task automatic sendFrame(input logic [8:0] bits, input int n, input bit do_start,
                           input bit gapped, input bit clr_last, input logic exp_err,
                           input string tag);
    if (do_start) begin
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      s_bit       = bits[i];
      s_bit_valid = 1'b1;
      if (clr_last && i == n - 1) clear_err = 1'b1;
      tick();
      s_bit_valid = 1'b0;
      clear_err   = 1'b0;
      if (i < n - 1) begin
        checkOutput({tag, " early frame_done"}, frame_done, 0);
        if (gapped) tick();
      end
    end
    checkOutput({tag, " frame_done"}, frame_done, 1);
    checkOutput({tag, " par_err"}, par_err, exp_err);
  endtask

  initial begin
    tx_vecs[0]  = '{8'hA5, 2'b00, 4'd8,  1'b0};
    tx_vecs[1]  = '{8'hA5, 2'b01, 4'd8,  1'b1};
    tx_vecs[2]  = '{8'hA5, 2'b10, 4'd8,  1'b1};
    tx_vecs[3]  = '{8'hA5, 2'b11, 4'd8,  1'b0};
    tx_vecs[4]  = '{8'h81, 2'b00, 4'd7,  1'b1};
    tx_vecs[5]  = '{8'h81, 2'b00, 4'd0,  1'b0};
    tx_vecs[6]  = '{8'h81, 2'b01, 4'd7,  1'b0};
    tx_vecs[7]  = '{8'hFF, 2'b00, 4'd5,  1'b1};
    tx_vecs[8]  = '{8'h1F, 2'b00, 4'd9,  1'b1};
    tx_vecs[9]  = '{8'h00, 2'b01, 4'd3,  1'b1};
    tx_vecs[10] = '{8'hFF, 2'b00, 4'd15, 1'b0};
    tx_vecs[11] = '{8'h3C, 2'b01, 4'd1,  1'b1};

    reset       = 1'b0;
    par_en      = 1'b0;
    par_typ     = 2'b00;
    cfg_len     = 4'd8;
    p_data      = 8'h00;
    data_valid  = 1'b0;
    s_start     = 1'b0;
    s_bit       = 1'b0;
    s_bit_valid = 1'b0;
    clear_err   = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");
    reset = 1'b1;
    tick();

    $display("[TB] TX parity vectors, back to back");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tx_vecs[i]);
      tick();
      checkOutput($sformatf("tx%0d par_valid", i), par_valid, 1);
      checkOutput($sformatf("tx%0d par_bit", i), par_bit, tx_vecs[i].exp_par);
    end
    data_valid = 1'b0;
    p_data     = 8'h00;
    tick();
    checkOutput("tx idle par_valid", par_valid, 0);
    checkOutput("tx hold par_bit", par_bit, 1);

    $display("[TB] RX frames");
    par_en  = 1'b1;
    par_typ = 2'b00;
    cfg_len = 4'd8;
    sendFrame({1'b0, 8'h3C}, 9, 1'b1, 1'b0, 1'b0, 1'b0, "rx even good");
    checkOutput("rx even good err_cnt", err_cnt, 0);
    checkOutput("rx even good err_sticky", err_sticky, 0);
    sendFrame({1'b1, 8'h3C}, 9, 1'b1, 1'b1, 1'b0, 1'b1, "rx even bad");
    checkOutput("rx even bad err_cnt", err_cnt, 1);
    checkOutput("rx even bad err_sticky", err_sticky, 1);
    tick();
    checkOutput("rx pulse end frame_done", frame_done, 0);
    checkOutput("rx pulse end par_err", par_err, 0);

    par_typ = 2'b01;
    cfg_len = 4'd6;
    sendFrame({3'b000, 6'b000111}, 7, 1'b1, 1'b0, 1'b0, 1'b0, "rx odd good");
    par_typ = 2'b10;
    sendFrame({3'b000, 6'b000111}, 7, 1'b1, 1'b0, 1'b0, 1'b1, "rx mark bad");
    checkOutput("rx mark err_cnt", err_cnt, 2);

    par_en  = 1'b0;
    par_typ = 2'b00;
    cfg_len = 4'd5;
    sendFrame({4'b0000, 5'b10110}, 5, 1'b1, 1'b1, 1'b0, 1'b0, "rx nopar L5");
    s_bit       = 1'b1;
    s_bit_valid = 1'b1;
    tick();
    s_bit_valid = 1'b0;
    checkOutput("rx idle bit frame_done", frame_done, 0);
    checkOutput("rx idle bit par_err", par_err, 0);

    // Abort after three bits; the restart collides with a bit strobe, and the
    // configuration is changed after the restart has latched it.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_bit       = 1'b1;
      s_bit_valid = 1'b1;
      tick();
      checkOutput("abort early frame_done", frame_done, 0);
    end
    s_start = 1'b1;
    tick();
    s_start     = 1'b0;
    s_bit_valid = 1'b0;
    checkOutput("abort restart frame_done", frame_done, 0);
    par_en  = 1'b1;
    cfg_len = 4'd8;
    sendFrame({4'b0000, 5'b11111}, 5, 1'b0, 1'b0, 1'b0, 1'b0, "rx restart");
    checkOutput("rx restart err_cnt", err_cnt, 2);

    $display("[TB] error accounting");
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checkOutput("clear err_cnt", err_cnt, 0);
    checkOutput("clear err_sticky", err_sticky, 0);
    par_typ = 2'b00;
    for (int i = 0; i < 5; i++) begin
      sendFrame({1'b1, 8'h3C}, 9, 1'b1, 1'b0, 1'b0, 1'b1, $sformatf("bad%0d", i));
      checkOutput($sformatf("bad%0d err_cnt", i), err_cnt, (i + 1 > 3) ? 3 : i + 1);
      checkOutput($sformatf("bad%0d err_sticky", i), err_sticky, 1);
    end
    sendFrame({1'b1, 8'h3C}, 9, 1'b1, 1'b0, 1'b1, 1'b1, "clr with err");
    checkOutput("clr with err err_cnt", err_cnt, 1);
    checkOutput("clr with err err_sticky", err_sticky, 1);

    $display("[TB] reset while waiting for parity");
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_bit       = 1'b0;
      s_bit_valid = 1'b1;
      tick();
    end
    s_bit_valid = 1'b0;
    reset = 1'b0;
    tick();
    checkAllZero("mid reset");
    reset       = 1'b1;
    s_bit       = 1'b1;
    s_bit_valid = 1'b1;
    tick();
    s_bit_valid = 1'b0;
    checkOutput("post reset stray frame_done", frame_done, 0);
    checkOutput("post reset stray par_err", par_err, 0);
    sendFrame({1'b0, 8'h3C}, 9, 1'b1, 1'b0, 1'b0, 1'b0, "post reset");
    checkOutput("post reset err_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
